calc_operand_stack: RTL

- Parametrised LIFO operand stack that generalises the single load register to DEPTH entries of WIDTH bits.
- Sits between the keypad/number-entry logic and the ALU.
- Executes one stack command per cycle: push, pop, swap, dup, load-top, clear.
- Exposes the top two entries as ALU operands, plus occupancy and error status.

---
 rtl/calc_operand_stack.sv | 120 ++++++++++++
 1 files changed

// File: rtl/calc_operand_stack.sv
// rtl/calc_operand_stack.sv - LIFO operand stack feeding the ALU operands (top/second).
// Optional stack-lift on PUSH/DUP when full: define CALC_OPERAND_STACK_LIFT_EN.
module calc_operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic             done
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_DUP  = 3'b100;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_CNT  = CW'(2);

  logic [WIDTH-1:0] r_ent [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_err;
  logic             r_done;

  logic [WIDTH-1:0] w_nxt [DEPTH];
  logic [CW-1:0]    w_nxt_count;
  logic             w_full;
  logic             w_empty;
  logic             w_room;
  logic             w_legal;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

`ifdef CALC_OPERAND_STACK_LIFT_EN
  assign w_room = 1'b1;
`else
  assign w_room = !w_full;
`endif

  // Slots at index >= count are kept zero, so shifts need no masking.
  always_comb begin
    w_legal     = 1'b0;
    w_nxt       = r_ent;
    w_nxt_count = r_count;
    case (op)
      OP_NOP: w_legal = 1'b1;
      OP_PUSH, OP_DUP: begin
        w_legal = w_room && ((op == OP_PUSH) || !w_empty);
        for (int i = 1; i < DEPTH; i++) w_nxt[i] = r_ent[i-1];
        w_nxt[0] = (op == OP_PUSH) ? d : r_ent[0];
        if (!w_full) w_nxt_count = r_count + 1'b1;
      end
      OP_POP: begin
        w_legal = !w_empty;
        for (int i = 0; i < DEPTH-1; i++) w_nxt[i] = r_ent[i+1];
        w_nxt[DEPTH-1] = '0;
        w_nxt_count    = r_count - 1'b1;
      end
      OP_SWAP: begin
        w_legal  = (r_count >= TWO_CNT);
        w_nxt[0] = r_ent[1];
        w_nxt[1] = r_ent[0];
      end
      OP_LOAD: begin
        w_legal  = !w_empty;
        w_nxt[0] = d;
      end
      OP_CLR: begin
        w_legal = 1'b1;
        for (int i = 0; i < DEPTH; i++) w_nxt[i] = '0;
        w_nxt_count = '0;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (op_valid) begin
        if (!w_legal) begin
          r_err <= 1'b1;
        end else if (op != OP_NOP) begin
          r_ent   <= w_nxt;
          r_count <= w_nxt_count;
          r_done  <= 1'b1;
          if (op == OP_CLR) r_err <= 1'b0;
        end
      end
    end
  end

  assign top    = r_ent[0];
  assign second = r_ent[1];
  assign count  = r_count;
  assign empty  = w_empty;
  assign full   = w_full;
  assign err    = r_err;
  assign done   = r_done;

endmodule
